// File: rtl/fir_pkg.sv
// Shared FIR constants and types used by the filter core and its output requantizer.
package fir_pkg;
  localparam int BIT_PREC  = 16;
  localparam int TAPS      = 9;
  localparam int FIR_OUT_W = 2*BIT_PREC + TAPS - 1;
  localparam int REQ_SHIFT = 8;
  localparam int REQ_DEPTH = 4;

  typedef logic signed [BIT_PREC-1:0] sample_t;
endpackage

// File: rtl/fir_out_fifo.sv
// First-word fall-through FIFO; rdata shows the head word and reads as zero when empty.
module fir_out_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign level   = count;
  // A pop frees its slot before the full check, so a write to a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fir_out_requant.sv
// Decimates the full-precision FIR result, rounds/shifts/saturates it to sample width,
// and queues it for a valid/ready sink with sticky clip and drop flags.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter  int IN_W  = FIR_OUT_W,
  parameter  int OUT_W = BIT_PREC,
  parameter  int SHIFT = REQ_SHIFT,
  parameter  int DECIM = 1,
  parameter  int DEPTH = REQ_DEPTH,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_wave,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic [LW-1:0]           level,
  output logic                    sat_flag,
  output logic                    ovf_flag,
  input  logic                    clr_flags
);
  localparam int CNT_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RND_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;

  logic [CNT_W-1:0]        dcnt;
  logic                    keep;
  logic signed [IN_W:0]    rnd, rounded, s1_val, sat_max, sat_min;
  logic                    s1_valid, s2_valid;
  logic signed [OUT_W-1:0] s2_data, sat_word;
  logic                    clip, sat_evt, ovf_evt, pop, full, empty;
  logic [OUT_W-1:0]        fifo_rdata;

  assign keep = in_valid && (dcnt == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rnd              = '0;
    rnd[RND_BIT]     = (SHIFT > 0);
    sat_max          = '0;
    sat_max[OUT_W-2:0] = '1;
    sat_min          = '1;
    sat_min[OUT_W-2:0] = '0;
    clip             = 1'b0;
    sat_word         = s1_val[OUT_W-1:0];
    if (s1_val > sat_max) begin
      clip     = 1'b1;
      sat_word = sat_max[OUT_W-1:0];
    end else if (s1_val < sat_min) begin
      clip     = 1'b1;
      sat_word = sat_min[OUT_W-1:0];
    end
  end

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  assign rounded = signed'({in_wave[IN_W-1], in_wave}) + rnd;

  assign pop     = out_valid & out_ready;
  assign sat_evt = s1_valid & clip;
  assign ovf_evt = s2_valid & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt     <= '0;
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (in_valid) dcnt <= (dcnt == CNT_W'(DECIM - 1)) ? '0 : dcnt + CNT_W'(1);
      s1_valid <= keep;
      if (keep) s1_val <= rounded >>> SHIFT;
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= sat_word;
      // A same-cycle event outranks the clear.
      sat_flag <= (sat_flag & ~clr_flags) | sat_evt;
      ovf_flag <= (ovf_flag & ~clr_flags) | ovf_evt;
    end
  end

  fir_out_fifo #(.W(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_valid),
    .wdata (s2_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid = ~empty;
  assign out_data  = signed'(fifo_rdata);
endmodule

// File: tb/tb_fir_out_requant.sv
// Directed and randomized checks of fir_out_requant against a queue-based reference model.
module tb_fir_out_requant;
  localparam int IN_W = 24, OUT_W = 16, SHIFT = 8, DEPTH = 4;

  logic              clk, rst;
  logic              in_valid, out_ready, out_valid, sat_flag, ovf_flag, clr_flags;
  logic [IN_W-1:0]   in_wave;
  logic [OUT_W-1:0]  out_data;
  logic [2:0]        level;

  logic              in3_valid, out3_valid, ready3, clr3, sat3, ovf3;
  logic [IN_W-1:0]   in3_wave;
  logic [OUT_W-1:0]  out3_data;
  logic [2:0]        level3;

  int checks = 0;
  int errors = 0;

  // Reference model state for the DECIM=1 instance.
  logic [15:0] mq[$];
  bit          st1_v, st2_v, sat_m, ovf_m;
  longint      st1_q;
  logic [15:0] st2_w;
  int          got3[$];

  fir_out_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wave(in_wave), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .level(level), .sat_flag(sat_flag),
    .ovf_flag(ovf_flag), .clr_flags(clr_flags));

  fir_out_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(3), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in3_valid), .in_wave(in3_wave), .out_ready(ready3),
    .out_valid(out3_valid), .out_data(out3_data), .level(level3), .sat_flag(sat3),
    .ovf_flag(ovf3), .clr_flags(clr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q--;
    return q;
  endfunction

  task automatic mreset();
    mq.delete();
    st1_v = 0; st2_v = 0; sat_m = 0; ovf_m = 0;
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, mq.size() > 0);
    check("out_data", out_data, (mq.size() > 0) ? mq[0] : 16'h0);
    check("level", level, mq.size());
    check("sat_flag", sat_flag, sat_m);
    check("ovf_flag", ovf_flag, ovf_m);
  endtask

  // Drive one cycle on the DECIM=1 instance, advance the model, then compare at the falling edge.
  task automatic step(input bit v, input logic [IN_W-1:0] w, input bit r, input bit c);
    bit     pop, ovf_evt, sat_evt;
    longint x, cl;
    in_valid = v; in_wave = w; out_ready = r; clr_flags = c;
    pop     = (mq.size() > 0) && r;
    ovf_evt = st2_v && (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (st2_v && !ovf_evt) mq.push_back(st2_w);
    sat_evt = 0;
    if (st1_v) begin
      cl = st1_q;
      if (cl > 32767) begin cl = 32767; sat_evt = 1; end
      else if (cl < -32768) begin cl = -32768; sat_evt = 1; end
      st2_w = 16'(cl);
    end
    st2_v = st1_v;
    st1_v = v;
    if (v) begin
      x = $signed(w);
      st1_q = floor_div(x + 128, 256);
    end
    sat_m = (sat_m && !c) || sat_evt;
    ovf_m = (ovf_m && !c) || ovf_evt;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic collect3();
    if (out3_valid) got3.push_back(int'(out3_data));
  endtask

  initial begin
    int exp3[3];
    logic [IN_W-1:0] w;
    exp3[0] = 1; exp3[1] = 4; exp3[2] = 7;
    rst = 0; in_valid = 0; in_wave = '0; out_ready = 0; clr_flags = 0;
    in3_valid = 0; in3_wave = '0; ready3 = 1; clr3 = 0;
    mreset();

    // Power-on reset
    #1 rst = 1;
    #2;
    compare_all();
    check("reset_out3_valid", out3_valid, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    compare_all();

    // Rounding: 384 -> 2, -128 -> 0, -129 -> -1
    step(1, 24'h000180, 0, 0);
    step(1, 24'hFFFF80, 0, 0);
    step(1, 24'hFFFF7F, 0, 0);
    check("round_valid_3_edges", out_valid, 1);
    check("round_384", out_data, 16'h0002);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    check("round_level", level, 3);
    step(0, '0, 1, 0);
    check("round_m128", out_data, 16'h0000);
    step(0, '0, 1, 0);
    check("round_m129", out_data, 16'hFFFF);
    step(0, '0, 1, 0);
    check("round_no_sat", sat_flag, 0);

    // Saturation and flag clearing
    step(1, 24'h7FFFFF, 0, 0);
    step(1, 24'h800000, 0, 0);
    check("sat_set", sat_flag, 1);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    check("sat_max_word", out_data, 16'h7FFF);
    step(0, '0, 1, 0);
    check("sat_min_word", out_data, 16'h8000);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);
    check("sat_cleared", sat_flag, 0);
    step(1, 24'h7FFFFF, 1, 0);
    step(0, '0, 1, 1);
    check("sat_event_beats_clear", sat_flag, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
    step(0, '0, 1, 1);

    // Overflow: six words into a four-deep FIFO with the sink stalled
    for (int k = 1; k <= 6; k++) step(1, IN_W'(k * 256), 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    check("ovf_level_full", level, 4);
    check("ovf_flag_set", ovf_flag, 1);
    for (int k = 1; k <= 4; k++) begin
      check("ovf_drain_order", out_data, 16'(k));
      step(0, '0, 1, 0);
    end
    check("ovf_level_empty", level, 0);
    step(0, '0, 0, 1);
    check("ovf_cleared", ovf_flag, 0);

    // Full FIFO with a pop on the edge the next word arrives
    for (int k = 10; k <= 14; k++) step(1, IN_W'(k * 256), 0, 0);
    step(0, '0, 0, 0);
    check("fullpop_level_before", level, 4);
    step(0, '0, 1, 0);
    check("fullpop_level_after", level, 4);
    check("fullpop_no_ovf", ovf_flag, 0);
    for (int k = 11; k <= 14; k++) begin
      check("fullpop_order", out_data, 16'(k));
      step(0, '0, 1, 0);
    end
    check("fullpop_empty", level, 0);

    // Decimation by 3 with input gaps
    for (int i = 1; i <= 9; i++) begin
      in3_valid = 1; in3_wave = IN_W'(i * 256);
      @(posedge clk); @(negedge clk);
      collect3();
      in3_valid = 0;
      if (i % 2 == 0) begin
        @(posedge clk); @(negedge clk);
        collect3();
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      collect3();
    end
    check("decim_count", got3.size(), 3);
    for (int i = 0; i < got3.size() && i < 3; i++) check("decim_word", got3[i], exp3[i]);
    check("decim_level", level3, 0);

    // Asynchronous reset mid-stream; dut3 left with a nonzero decimation phase
    in3_valid = 1; in3_wave = IN_W'(10 * 256);
    step(1, 24'h7FFFFF, 0, 0);
    in3_wave = IN_W'(11 * 256);
    step(1, IN_W'(256), 0, 0);
    in3_valid = 0;
    step(1, IN_W'(512), 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    check("midreset_level_before", level, 3);
    #2 rst = 1;
    mreset();
    #1;
    compare_all();
    check("midreset_out_data", out_data, 16'h0);
    check("midreset_out3_valid", out3_valid, 0);
    @(negedge clk);
    rst = 0;
    in3_valid = 1; in3_wave = IN_W'(12 * 256);
    step(1, IN_W'(5 * 256), 0, 0);
    in3_valid = 0;
    step(0, '0, 0, 0);
    check("postreset_not_early", out_valid, 0);
    step(0, '0, 0, 0);
    check("postreset_valid", out_valid, 1);
    check("postreset_data", out_data, 16'd5);
    check("postreset_dcnt_zero_valid", out3_valid, 1);
    check("postreset_dcnt_zero_data", out3_data, 16'd12);
    step(0, '0, 1, 0);

    // Randomized traffic with alternating stall-heavy and drain-heavy phases
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       w = 24'h7FFFFF;
        1:       w = 24'h800000;
        2:       w = 24'h7FFF80;
        3:       w = 24'h7FFF7F;
        default: w = IN_W'($urandom);
      endcase
      step(bit'($urandom_range(0, 1)), w,
           ((i / 25) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
Output-side companion to the transposed FIR. It takes the full-precision FIR result and decimates it. It then rounds, shifts and saturates the result back to sample width, and buffers it in a small FIFO. A valid/ready handshake delivers it to the downstream sink (DAC model, file writer, next stage). It also reports sticky saturation and overflow status.

Parameters:
IN_W, FIR_OUT_W (fir_pkg, = 2*BIT_PREC+TAPS-1), width of the signed FIR result
OUT_W, BIT_PREC (fir_pkg), width of the signed output sample
SHIFT, 8, right-shift applied after rounding (0..IN_W-1)
DECIM, 1, keep 1 of every DECIM accepted input samples (>=1)
DEPTH, 4, FIFO depth in words (power of two, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_wave carries a new FIR result this cycle (driven alongside fir_en)
in_wave  in  IN_W  signed full-precision FIR output
out_ready  in  1  sink accepts out_data this cycle
out_valid  out  1  out_data holds a valid sample
out_data  out  OUT_W  signed requantized sample, FIFO head (first-word fall-through)
level  out  $clog2(DEPTH+1)  current FIFO occupancy
sat_flag  out  1  sticky: at least one sample was clipped
ovf_flag  out  1  sticky: at least one sample was dropped because the FIFO was full
clr_flags  in  1  synchronous clear of sat_flag/ovf_flag

Behaviour:
- Reset (async, any time, mid-stream included): out_valid=0, level=0, out_data=0, sat_flag=0, ovf_flag=0, decimation counter=0, pipeline valids=0. FIFO contents are discarded.
- Decimation: counter dcnt counts in_valid cycles modulo DECIM. A sample is kept when in_valid=1 and dcnt==0. dcnt increments on every in_valid and wraps from DECIM-1 to 0. When DECIM=1, every sample is kept.
- Stage 1 (edge E0, kept sample):
  - r = in_wave + 2^(SHIFT-1), computed in IN_W+1 bits, signed.
  - Arithmetic shift right by SHIFT.
  - With SHIFT=0 there is no rounding add.
  - Rounding is round-half-up, i.e. floor(x/2^SHIFT + 0.5).
- Stage 2 (E1): saturate to signed OUT_W.
  - Values above 2^(OUT_W-1)-1 are clipped to that maximum.
  - Values below -2^(OUT_W-1) are clipped to that minimum.
  - Any clip sets sat_flag.
- FIFO write (E2): the stage-2 word is written if not full.
  - If full, the word is dropped and ovf_flag is set.
  - Exception: a pop in the same cycle frees the slot, and the write is accepted. Pop is evaluated before the full check.
- Latency: sample kept at E0 → out_valid=1 after E2 when the FIFO was empty. There is no bypass; an empty FIFO always takes 3 edges.
- Handshake:
  - A pop occurs on an edge with out_valid & out_ready.
  - out_data and out_valid are stable while out_valid=1 & out_ready=0.
  - out_ready while out_valid=0 has no effect.
- level:
  - +1 on write only, -1 on pop only.
  - Unchanged on a simultaneous write+pop, or when neither occurs.
  - Pointers wrap modulo DEPTH.
- Pipeline never stalls: the stages advance every cycle, and backpressure only causes drops.
- clr_flags=1 clears the flags at the next edge. If a saturation or drop event occurs in that same cycle, the event wins and the flag stays 1.

Decomposition:
- fir_pkg gains:
  - localparam FIR_OUT_W = 2*BIT_PREC+TAPS-1
  - localparams REQ_SHIFT and REQ_DEPTH, used as the defaults
  - typedef logic signed [BIT_PREC-1:0] sample_t
- One sub-module, fir_out_fifo: synchronous first-word fall-through FIFO with push, pop, full, empty and level.
- Rounding, decimation and flag logic stay in fir_out_requant.

Test Plan:
Bench parameters: IN_W=24, OUT_W=16, SHIFT=8, DEPTH=4, DECIM=1 unless stated.
- Rounding: in 0x000180 (384) → out_data 0x0002 with out_valid high after 3 edges. In 0xFFFF80 (-128) → 0x0000. In 0xFFFF7F (-129) → 0xFFFF. sat_flag stays 0 throughout.
- Saturation: in 0x7FFFFF → 0x7FFF and sat_flag=1. In 0x800000 → 0x8000 with no new clip. clr_flags pulse → sat_flag=0. clr_flags asserted in the same cycle as a clipping word → sat_flag remains 1.
- Overflow: out_ready=0, 6 consecutive kept samples 1..6 (×256) → level=4, ovf_flag=1. Then out_ready=1 → outputs 1,2,3,4 only, and level returns to 0.
- Full with simultaneous pop: FIFO full, out_ready=1 on the edge the next word arrives → word accepted, level stays 4, ovf_flag stays 0, order preserved.
- Decimation (DECIM=3): 9 valid inputs 1..9 (×256), with in_valid gaps inserted → outputs 1,4,7.
- Reset mid-stream: rst asserted asynchronously with level=3 → out_valid, level and flags go to 0 immediately, without a clock edge. After release, the first valid input is kept (dcnt=0) and emerges 3 edges later.
